// File: rtl/isle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : isle_pkg
//  Brief    : Shared types for the canvas / video-RAM blocks: memory-port
//             grant owner, arbiter state, and a run-counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package isle_pkg;

  // Owner of the single RAM port in a given cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_SYS  = 2'd2
  } va_grant_e;

  // Video RAM arbiter states
  typedef enum logic [1:0] {
    VA_IDLE  = 2'd0,
    VA_BURST = 2'd1,
    VA_DRAIN = 2'd2
  } va_state_e;

  // Bits needed to count display reads up to 'every' (at least one bit)
  function automatic int va_run_width(input int every);
    return (every < 2) ? 1 : $clog2(every + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vram_burst_gen
//  Brief    : Display burst bookkeeping: next read address (wraps at the top
//             of memory), words still to issue, and the run of display reads
//             since the last system slot.
//  Revision : 1.0  initial release
// ============================================================================
module vram_burst_gen
  import isle_pkg::*;
#(
  parameter int ADDRW     = 16,
  parameter int LENW      = 10,
  parameter int SYS_EVERY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ADDRW-1:0] load_addr,
  input  logic [LENW-1:0]  load_len,
  input  logic             step,
  input  logic             slot,
  output logic [ADDRW-1:0] addr,
  output logic             last,
  output logic             run_full
);

  localparam int                c_run_w   = va_run_width(SYS_EVERY);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(SYS_EVERY);

  logic [ADDRW-1:0]   r_addr;
  logic [LENW-1:0]    r_count;
  logic [c_run_w-1:0] r_run;

  // Latch a new burst, then advance per display issue; a system slot restarts the run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_count <= '0;
      r_run   <= '0;
    end else if (load) begin
      r_addr  <= load_addr;
      r_count <= load_len;
      r_run   <= '0;
    end else if (step) begin
      r_addr  <= r_addr + ADDRW'(1);
      r_count <= r_count - LENW'(1);
      if (r_run != c_run_max) begin
        r_run <= r_run + c_run_w'(1);
      end
    end else if (slot) begin
      r_run <= '0;
    end
  end

  assign addr     = r_addr;
  assign last     = (r_count == LENW'(1));
  // With SYS_EVERY = 0 the display never yields mid-burst
  assign run_full = (SYS_EVERY != 0) && (r_run == c_run_max);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Brief    : Shares one single-port bitmap RAM between the display line
//             fetch (prioritised read bursts) and the system port (single
//             reads/writes in idle cycles and a slot every SYS_EVERY reads).
//  Revision : 1.0  initial release
// ============================================================================
module vram_arbiter
  import isle_pkg::*;
#(
  parameter int ADDRW     = 16,
  parameter int DATAW     = 16,
  parameter int LENW      = 10,
  parameter int SYS_EVERY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_start,
  input  logic [ADDRW-1:0] disp_addr,
  input  logic [LENW-1:0]  disp_len,
  output logic             disp_busy,
  output logic [DATAW-1:0] disp_rdata,
  output logic             disp_rvalid,
  input  logic             sys_valid,
  input  logic             sys_we,
  input  logic [ADDRW-1:0] sys_addr,
  input  logic [DATAW-1:0] sys_wdata,
  output logic             sys_ready,
  output logic [DATAW-1:0] sys_rdata,
  output logic             sys_rvalid,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_we,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata
);

  va_state_e        r_state;
  va_grant_e        w_grant;
  logic             w_start;
  logic             w_last;
  logic             w_run_full;
  logic [ADDRW-1:0] w_burst_addr;
  logic [ADDRW-1:0] r_last_addr;
  logic             r_disp_rvalid;
  logic             r_sys_rvalid;

  // Zero-length requests and requests during a burst are dropped here
  assign w_start = (r_state == VA_IDLE) && disp_start && (disp_len != '0);

  // Decide who owns the RAM port this cycle; nobody while reset is held
  always_comb begin
    w_grant = GNT_NONE;
    case (r_state)
      VA_IDLE, VA_DRAIN: if (sys_valid) w_grant = GNT_SYS;
      VA_BURST:          w_grant = (w_run_full && sys_valid) ? GNT_SYS : GNT_DISP;
      default:           w_grant = GNT_NONE;
    endcase
    if (!rst_n) w_grant = GNT_NONE;
  end

  // RAM address follows the grant; with no grant it parks on the last address used
  always_comb begin
    case (w_grant)
      GNT_DISP: mem_addr = w_burst_addr;
      GNT_SYS:  mem_addr = sys_addr;
      default:  mem_addr = r_last_addr;
    endcase
  end

  vram_burst_gen #(
    .ADDRW     (ADDRW),
    .LENW      (LENW),
    .SYS_EVERY (SYS_EVERY)
  ) u_burst_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_start),
    .load_addr (disp_addr),
    .load_len  (disp_len),
    .step      (w_grant == GNT_DISP),
    .slot      ((w_grant == GNT_SYS) && (r_state == VA_BURST)),
    .addr      (w_burst_addr),
    .last      (w_last),
    .run_full  (w_run_full)
  );

  // Arbiter state plus return tags marking whose read comes back next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= VA_IDLE;
      r_disp_rvalid <= 1'b0;
      r_sys_rvalid  <= 1'b0;
      r_last_addr   <= '0;
    end else begin
      case (r_state)
        VA_IDLE:  if (w_start) r_state <= VA_BURST;
        VA_BURST: if ((w_grant == GNT_DISP) && w_last) r_state <= VA_DRAIN;
        default:  r_state <= VA_IDLE;
      endcase
      r_disp_rvalid <= (w_grant == GNT_DISP);
      r_sys_rvalid  <= (w_grant == GNT_SYS) && !sys_we;
      if (w_grant != GNT_NONE) r_last_addr <= mem_addr;
    end
  end

  assign disp_busy   = (r_state != VA_IDLE);
  assign disp_rvalid = r_disp_rvalid;
  assign disp_rdata  = mem_rdata;
  assign sys_rvalid  = r_sys_rvalid;
  assign sys_rdata   = mem_rdata;
  assign sys_ready   = (w_grant == GNT_SYS);
  assign mem_we      = (w_grant == GNT_SYS) && sys_we;
  assign mem_wdata   = sys_wdata;

endmodule
`default_nettype wire
